// File: rtl/chunk_adder_seq_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package chunk_adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of chunk steps needed to cover the full operand width.
    function automatic int nchunk_of(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    // Chunk counter width; a single-step adder still gets a 1-bit counter.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = nchunk_of(width, chunk);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder_seq_if.sv
// Operand/result handshake bundle for chunk_adder_seq.
// The sub signal exists only when ADDSUB_EN is defined.
interface chunk_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDSUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef ADDSUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef ADDSUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunk_adder_seq_chunk_add.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the top bit
// so the caller can form two's-complement overflow on the final chunk.
module chunk_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = i_ci;

    // Full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic w_p;
        assign w_p        = i_x[i] ^ i_y[i];
        assign o_s[i]     = w_p ^ w_c[i];
        assign w_c[i + 1] = (i_x[i] & i_y[i]) | (w_p & w_c[i]);
    end

    assign o_co    = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/chunk_adder_seq.sv
// Multi-cycle adder: adds a + b + cin CHUNK bits per clock with a registered
// carry between chunks. Optional subtract mode under macro ADDSUB_EN.
//
// state | meaning
// IDLE  | waiting for an operand word, in_ready high
// RUN   | one chunk added per cycle
// DONE  | result presented, waiting for out_ready
module chunk_adder_seq
    import chunk_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    chunk_adder_seq_if.slave  bus
);
    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("chunk_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cout;
    logic               r_ovf;
    logic               r_sub;
    logic               w_last;
    logic               w_init_carry;
    logic [CHUNK-1:0]   w_x;
    logic [CHUNK-1:0]   w_y;
    logic [CHUNK-1:0]   w_s;
    logic               w_co;
    logic               w_c_msb;
    logic               w_in_ready;
    logic               w_out_valid;

`ifdef ADDSUB_EN
    // Subtraction is a + ~b + 1, so the starting carry is forced to 1.
    assign w_init_carry = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_init_carry = bus.cin;
`endif

    assign w_last = (r_cnt == LAST_CNT);
    assign w_x    = r_a[r_cnt*CHUNK +: CHUNK];
    assign w_y    = r_b[r_cnt*CHUNK +: CHUNK] ^ {CHUNK{r_sub}};

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .i_x     (w_x),
        .i_y     (w_y),
        .i_ci    (r_carry),
        .o_s     (w_s),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs straight from the state register.
    always_comb begin
        w_in_ready  = (r_state == ST_IDLE);
        w_out_valid = (r_state == ST_DONE);
    end

    // Operand capture on accept, then one chunk of sum per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= w_init_carry;
                        r_cnt   <= '0;
                        r_sum   <= '0;
`ifdef ADDSUB_EN
                        r_sub   <= bus.sub;
`else
                        r_sub   <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    r_sum[r_cnt*CHUNK +: CHUNK] <= w_s;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_c_msb;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_chunk_adder_seq.sv
// Directed bench for chunk_adder_seq: CHUNK=2 main instance plus CHUNK=8 and
// CHUNK=1 instances for the latency extremes. Subtract vectors need ADDSUB_EN.
module tb_chunk_adder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunk_adder_seq_if #(.WIDTH(8)) if0 ();
    chunk_adder_seq_if #(.WIDTH(8)) if8 ();
    chunk_adder_seq_if #(.WIDTH(8)) if1 ();

    chunk_adder_seq #(.WIDTH(8), .CHUNK(2)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(if0));
    chunk_adder_seq #(.WIDTH(8), .CHUNK(8)) u_dut_w (.clk(clk), .rst_n(rst_n), .bus(if8));
    chunk_adder_seq #(.WIDTH(8), .CHUNK(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run one operation on the CHUNK=2 instance; hold_cyc > 0 exercises backpressure.
    task automatic op2(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic s, input logic [7:0] e_sum,
                       input logic e_co, input logic e_ov, input int hold_cyc);
        int lat;
        check_val({tag, "_in_ready"}, 32'(if0.in_ready), 32'd1);
        if0.in_valid = 1'b1;
        if0.a = a;
        if0.b = b;
        if0.cin = ci;
`ifdef ADDSUB_EN
        if0.sub = s;
`else
        if (s) $display("note: sub requested without ADDSUB_EN");
`endif
        tick;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 20) begin
            tick;
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_sum"}, 32'(if0.sum), 32'(e_sum));
        check_val({tag, "_cout"}, 32'(if0.cout), 32'(e_co));
        check_val({tag, "_ovf"}, 32'(if0.ovf), 32'(e_ov));
        for (int i = 0; i < hold_cyc; i++) begin
            if0.in_valid = 1'b1;
            if0.a = 8'(i * 17);
            if0.b = 8'h33;
            tick;
            check_val({tag, "_bp_sum"}, 32'(if0.sum), 32'(e_sum));
            check_val({tag, "_bp_flags"}, {30'd0, if0.cout, if0.ovf}, {30'd0, e_co, e_ov});
            check_val({tag, "_bp_in_ready"}, 32'(if0.in_ready), 32'd0);
            check_val({tag, "_bp_out_valid"}, 32'(if0.out_valid), 32'd1);
        end
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        tick;
        if0.out_ready = 1'b0;
        check_val({tag, "_idle_in_ready"}, 32'(if0.in_ready), 32'd1);
        check_val({tag, "_idle_out_valid"}, 32'(if0.out_valid), 32'd0);
    endtask

    initial begin
        int lat_w;
        int lat_b;
        logic [7:0] s_w;
        logic [7:0] s_b;
        logic c_w, c_b, o_w, o_b;

        if0.in_valid = 0; if0.a = 0; if0.b = 0; if0.cin = 0; if0.out_ready = 0;
        if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.out_ready = 0;
        if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.cin = 0; if1.out_ready = 0;
`ifdef ADDSUB_EN
        if0.sub = 0; if8.sub = 0; if1.sub = 0;
`endif
        tick;
        tick;
        check_val("rst_in_ready", 32'(if0.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check_val("rst_sum", 32'(if0.sum), 32'd0);
        check_val("rst_flags", {30'd0, if0.cout, if0.ovf}, 32'd0);
        rst_n = 1'b1;
        tick;

        op2("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op2("7f_p_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op2("12_p_34c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);
        op2("80_p_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        op2("ff_p_ffc", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        op2("bp", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 5);
        op2("post_bp", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);

        // Abort mid-RUN after two chunks: 0x55+0x22 has low nibble 0x7 by then.
        if0.in_valid = 1'b1; if0.a = 8'h55; if0.b = 8'h22; if0.cin = 1'b0;
        tick;
        if0.in_valid = 1'b0;
        tick;
        tick;
        check_val("mid_partial_sum", 32'(if0.sum), 32'h07);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 32'(if0.out_valid), 32'd0);
        check_val("mid_rst_in_ready", 32'(if0.in_ready), 32'd1);
        check_val("mid_rst_sum", 32'(if0.sum), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        op2("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0);

`ifdef ADDSUB_EN
        op2("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        op2("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        op2("sub0_add", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);
`endif

        // Latency extremes: CHUNK=8 finishes in 1 cycle, CHUNK=1 in 8.
        if8.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if8.in_valid = 1'b1; if8.a = 8'hA5; if8.b = 8'h5A; if8.cin = 1'b1;
        if1.in_valid = 1'b1; if1.a = 8'hA5; if1.b = 8'h5A; if1.cin = 1'b1;
        tick;
        if8.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        lat_w = -1; lat_b = -1;
        s_w = 8'h11; s_b = 8'h11; c_w = 0; c_b = 0; o_w = 1; o_b = 1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick;
            if (if8.out_valid && lat_w < 0) begin
                lat_w = c - 1; s_w = if8.sum; c_w = if8.cout; o_w = if8.ovf;
            end
            if (if1.out_valid && lat_b < 0) begin
                lat_b = c - 1; s_b = if1.sum; c_b = if1.cout; o_b = if1.ovf;
            end
        end
        check_val("w8_latency", 32'(lat_w), 32'd1);
        check_val("w8_sum", 32'(s_w), 32'h00);
        check_val("w8_flags", {30'd0, c_w, o_w}, 32'b10);
        check_val("w1_latency", 32'(lat_b), 32'd8);
        check_val("w1_sum", 32'(s_b), 32'h00);
        check_val("w1_flags", {30'd0, c_b, o_b}, 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/chunk_adder_seq.md
# chunk_adder_seq

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus a carry-in over WIDTH/CHUNK clock cycles. It processes CHUNK bits per cycle and keeps a registered carry between chunks. It is the sequential, width-generic successor to the single-bit half-adder cell. It sits in the datapath feeding the 8-bit multiplier's partial-product accumulation, behind a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 8, operand and result width; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; legal range 1..WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept an operand word; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  subtract select; present only with ADDSUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on in_valid && in_ready. On that edge:
  - latch a and b into operand registers;
  - set carry register to cin;
  - set chunk counter to 0;
  - clear the sum register.
- RUN, chunk k (k = 0..NCHUNK-1), one per cycle:
  - compute a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + carry;
  - write the result into sum[k*CHUNK +: CHUNK];
  - update carry;
  - when k = NCHUNK-1, also capture the carry into the MSB for ovf.
- RUN → DONE on the edge that processes chunk NCHUNK-1. cout and ovf are registered on that edge.
- DONE → IDLE on out_valid && out_ready.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum, cout and ovf hold stable from the start of DONE until the next accept edge clears sum.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the (WIDTH+1)-th bit. ovf is meaningful for signed operands.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE, so in_ready = 1;
  - out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - carry register and chunk counter = 0.
- Reset during RUN or DONE aborts the operation and discards the result.
- Latency: out_valid rises NCHUNK cycles after the accept edge. With CHUNK = WIDTH this is 1 cycle.
- in_ready = (state == IDLE), driven combinationally from the state register.
- out_valid = (state == DONE), driven combinationally from the state register.
- No accept is possible in the cycle of the output handshake. in_ready rises the cycle after it.
- Peak throughput: one result per NCHUNK+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready = 0, and in_ready stays 0 for that whole time.

## Configuration
- ADDSUB_EN defined:
  - the sub port exists and is latched on the accept edge;
  - sub = 1 computes a - b as a + ~b + 1; cin is ignored and the initial carry is 1;
  - cout = 1 means no borrow;
  - sub = 0 gives plain addition as below.
- ADDSUB_EN undefined: no sub port; the block only computes a + b + cin.

## Structure
- Shared package holds:
  - the FSM state typedef (IDLE/RUN/DONE, 2-bit encoding);
  - the function deriving NCHUNK and the counter width as $clog2(NCHUNK) with a floor of 1.
- One sub-module, chunk_add: combinational CHUNK-bit ripple adder built from a half-adder/full-adder chain.
  - Inputs: x[CHUNK], y[CHUNK], ci.
  - Outputs: s[CHUNK], co, c_msb (carry into the top bit).
- Top level holds the FSM, operand and sum registers, carry register and chunk counter.
- Elaboration check: fail if WIDTH % CHUNK != 0 or CHUNK < 1.

## Test plan
- WIDTH=8, CHUNK=2; a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; out_valid high exactly 4 cycles after the accept edge.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1; a=0x12, b=0x34, cin=1 → sum=0x47, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum/cout/ovf stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 chunks → out_valid=0, in_ready=1, sum=0 immediately; a following add 0x03+0x04 → 0x07.
- ADDSUB_EN, sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- CHUNK=WIDTH=8 and CHUNK=1: a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1; latency 1 and 8 cycles respectively.
